// File: rtl/pwm_reg_reader.sv
// -----------------------------------------------------------------------------
// pwm_reg_reader
//
// SPI-side readback responder for the PWM configuration registers. It listens
// to the same receive byte stream as the register writer and follows the
// writer's command framing, so that the four payload bytes of a write are never
// decoded as commands. A read opcode (RD_OPCODE_BASE + index, index 1..6)
// snapshots the selected 32-bit register. The snapshot is then handed to the
// SPI slave's transmit path one byte per received byte, LSB first. The byte
// order matches the write framing, so "write N, read N" returns the same bytes.
//
// Ports
//   i_Clk          in   1   clock, single domain
//   i_Rst          in   1   synchronous, active-high reset
//   o_RX_DV        in   1   one-cycle pulse: o_RX_Byte is valid
//   o_RX_Byte      in   8   byte received on MOSI
//   counter_value  in  32   register index 1
//   prescaler      in  32   register index 2
//   duty_cycle_1   in  32   register index 3
//   duty_cycle_2   in  32   register index 4
//   duty_cycle_3   in  32   register index 5
//   enable_pwm     in   1   register index 6, read as {31'b0, enable_pwm}
//   i_TX_DV        out  1   one-cycle pulse: load i_TX_Byte for the next MISO byte
//   i_TX_Byte      out  8   registered byte for MISO; holds between pulses
//   o_Rd_Busy      out  1   high while a read frame is being returned
// -----------------------------------------------------------------------------
module pwm_reg_reader #(
    parameter logic [7:0] RD_OPCODE_BASE = 8'h80
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        o_RX_DV,
    input  logic [7:0]  o_RX_Byte,
    input  logic [31:0] counter_value,
    input  logic [31:0] prescaler,
    input  logic [31:0] duty_cycle_1,
    input  logic [31:0] duty_cycle_2,
    input  logic [31:0] duty_cycle_3,
    input  logic        enable_pwm,
    output logic        i_TX_DV,
    output logic [7:0]  i_TX_Byte,
    output logic        o_Rd_Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic        tx_dv_q, tx_dv_d;
    logic [7:0]  tx_byte_q, tx_byte_d;

    // Read opcode decode: the offset from the base selects the register.
    logic [7:0]  rd_index;
    logic        rd_valid;
    logic [31:0] rd_value;

    assign rd_index = o_RX_Byte - RD_OPCODE_BASE;

    always_comb begin
        rd_valid = 1'b1;
        rd_value = 32'h0;
        case (rd_index)
            8'd1:    rd_value = counter_value;
            8'd2:    rd_value = prescaler;
            8'd3:    rd_value = duty_cycle_1;
            8'd4:    rd_value = duty_cycle_2;
            8'd5:    rd_value = duty_cycle_3;
            8'd6:    rd_value = {31'b0, enable_pwm};
            default: rd_valid = 1'b0;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;

        if (o_RX_DV) begin
            unique case (state_q)
                IDLE: begin
                    if (o_RX_Byte >= 8'h01 && o_RX_Byte <= 8'h05) begin
                        // Write command: its four payload bytes belong to the writer.
                        state_d = SKIP;
                        cnt_d   = 2'd0;
                    end else if (o_RX_Byte == 8'h06 || o_RX_Byte == 8'h07) begin
                        // Single-byte enable/disable commands carry no payload.
                        state_d = IDLE;
                    end else if (rd_valid) begin
                        shadow_d  = rd_value;
                        state_d   = SEND;
                        cnt_d     = 2'd1;
                        tx_dv_d   = 1'b1;
                        tx_byte_d = rd_value[7:0];
                    end
                end

                SKIP: begin
                    if (cnt_q == 2'd3) begin
                        state_d = IDLE;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end

                SEND: begin
                    tx_dv_d = 1'b1;
                    // cnt wraps 3 -> 0 after the MSB; 0 marks the trailing filler byte.
                    case (cnt_q)
                        2'd1:    tx_byte_d = shadow_q[15:8];
                        2'd2:    tx_byte_d = shadow_q[23:16];
                        2'd3:    tx_byte_d = shadow_q[31:24];
                        default: tx_byte_d = 8'h00;
                    endcase
                    if (cnt_q == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            shadow_q  <= 32'h0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    assign i_TX_DV   = tx_dv_q;
    assign i_TX_Byte = tx_byte_q;
    assign o_Rd_Busy = (state_q == SEND);

endmodule

// File: tb/tb_pwm_reg_reader.sv
// -----------------------------------------------------------------------------
// tb_pwm_reg_reader
//
// Self-checking bench for pwm_reg_reader. A byte-level reference model tracks
// the writer's framing as "payload bytes still to skip" and a pending read as a
// queue of bytes still to return. Each received byte is checked against the
// model for the TX pulse, the TX byte, the pulse width and o_Rd_Busy.
// -----------------------------------------------------------------------------
module tb_pwm_reg_reader;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b0;
    logic        o_RX_DV = 1'b0;
    logic [7:0]  o_RX_Byte = 8'h00;
    logic [31:0] counter_value = 32'h0;
    logic [31:0] prescaler = 32'h0;
    logic [31:0] duty_cycle_1 = 32'h0;
    logic [31:0] duty_cycle_2 = 32'h0;
    logic [31:0] duty_cycle_3 = 32'h0;
    logic        enable_pwm = 1'b0;
    logic        i_TX_DV;
    logic [7:0]  i_TX_Byte;
    logic        o_Rd_Busy;

    pwm_reg_reader #(.RD_OPCODE_BASE(8'h80)) dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .o_RX_DV       (o_RX_DV),
        .o_RX_Byte     (o_RX_Byte),
        .counter_value (counter_value),
        .prescaler     (prescaler),
        .duty_cycle_1  (duty_cycle_1),
        .duty_cycle_2  (duty_cycle_2),
        .duty_cycle_3  (duty_cycle_3),
        .enable_pwm    (enable_pwm),
        .i_TX_DV       (i_TX_DV),
        .i_TX_Byte     (i_TX_Byte),
        .o_Rd_Busy     (o_Rd_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_skip;          // write payload bytes still owed to the writer
    logic [7:0] m_rd_q[$];       // bytes of the current read still to return
    logic [7:0] m_last_tx;       // last byte presented on i_TX_Byte
    int         m_pulses;        // total TX pulses predicted

    function automatic logic [31:0] reg_value(input int idx);
        case (idx)
            1: return counter_value;
            2: return prescaler;
            3: return duty_cycle_1;
            4: return duty_cycle_2;
            5: return duty_cycle_3;
            6: return {31'b0, enable_pwm};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_skip = 0;
        m_rd_q.delete();
        m_last_tx = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] b, output logic pulse, output logic [7:0] tx);
        logic [31:0] v;
        pulse = 1'b0;
        tx    = m_last_tx;
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_rd_q.size() > 0) begin
            pulse = 1'b1;
            tx    = m_rd_q.pop_front();
        end else if (b >= 8'h01 && b <= 8'h05) begin
            m_skip = 4;
        end else if (b >= 8'h81 && b <= 8'h86) begin
            v = reg_value(int'(b) - 8'h80);
            pulse = 1'b1;
            tx    = v[7:0];
            m_rd_q.push_back(v[15:8]);
            m_rd_q.push_back(v[23:16]);
            m_rd_q.push_back(v[31:24]);
            m_rd_q.push_back(8'h00);
        end
        if (pulse) m_pulses++;
        m_last_tx = tx;
    endtask

    // ---------------- stimulus helpers ----------------
    int dut_pulses = 0;
    always @(negedge i_Clk) if (i_TX_DV === 1'b1) dut_pulses++;

    // Drives one received byte and checks the response one cycle later,
    // then checks the pulse has dropped again.
    task automatic send_byte(input logic [7:0] b);
        logic       exp_pulse;
        logic [7:0] exp_tx;
        @(negedge i_Clk);
        o_RX_DV   = 1'b1;
        o_RX_Byte = b;
        model_step(b, exp_pulse, exp_tx);
        @(negedge i_Clk);
        o_RX_DV = 1'b0;
        check($sformatf("tx_dv[rx=%02h]", b), {31'b0, i_TX_DV}, {31'b0, exp_pulse});
        check($sformatf("tx_byte[rx=%02h]", b), {24'b0, i_TX_Byte}, {24'b0, exp_tx});
        check($sformatf("busy[rx=%02h]", b), {31'b0, o_Rd_Busy}, {31'b0, (m_rd_q.size() > 0)});
        @(negedge i_Clk);
        check("tx_dv_width", {31'b0, i_TX_DV}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge i_Clk);
        i_Rst = 1'b1;
        @(negedge i_Clk);
        i_Rst = 1'b0;
        model_reset();
        check("rst_tx_dv", {31'b0, i_TX_DV}, 32'h0);
        check("rst_tx_byte", {24'b0, i_TX_Byte}, 32'h0);
        check("rst_busy", {31'b0, o_Rd_Busy}, 32'h0);
    endtask

    task automatic send_seq(input logic [7:0] s[]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [7:0] pick[] = '{8'h00, 8'h01, 8'h03, 8'h05, 8'h06, 8'h07, 8'h80,
                               8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'hFF};
        m_pulses = 0;
        model_reset();
        repeat (2) @(negedge i_Clk);
        do_reset();

        // Reset then read of counter_value.
        counter_value = 32'h11223344;
        send_seq('{8'h81, 8'h00, 8'h00, 8'h00, 8'h00});

        // Write frame then readback of duty_cycle_1.
        duty_cycle_1 = 32'hDDCCBBAA;
        p0 = dut_pulses;
        send_seq('{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
        check("no_tx_in_write", dut_pulses - p0, 0);
        send_seq('{8'h83, 8'h00, 8'h00, 8'h00, 8'h00});

        // Framing guard: read opcodes inside a write payload are data.
        p0 = dut_pulses;
        send_seq('{8'h01, 8'h82, 8'h86, 8'h81, 8'h85});
        check("guard_no_tx", dut_pulses - p0, 0);
        enable_pwm = 1'b1;
        send_seq('{8'h86, 8'h00, 8'h00, 8'h00, 8'h00});

        // Snapshot coherence: live change mid-frame is not visible.
        prescaler = 32'h000000FF;
        send_byte(8'h82);
        prescaler = 32'hFFFFFF00;
        send_seq('{8'h00, 8'h00, 8'h00, 8'h00});

        // Illegal opcodes, then single-byte command followed by a read.
        p0 = dut_pulses;
        send_seq('{8'h80, 8'h87, 8'h08, 8'hFF});
        check("illegal_no_tx", dut_pulses - p0, 0);
        duty_cycle_2 = 32'hCAFEF00D;
        send_seq('{8'h06, 8'h84, 8'h00, 8'h00, 8'h00, 8'h00});

        // Reset mid-read after the second TX pulse.
        duty_cycle_3 = 32'h55667788;
        send_seq('{8'h85, 8'h00});
        do_reset();
        p0 = dut_pulses;
        send_seq('{8'h00, 8'h00, 8'h00});
        check("post_rst_no_tx", dut_pulses - p0, 0);

        // Randomized traffic with occasional resets and live register changes.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                counter_value = $urandom;
                prescaler     = $urandom;
                duty_cycle_1  = $urandom;
                duty_cycle_2  = $urandom;
                duty_cycle_3  = $urandom;
                enable_pwm    = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 49) == 0) do_reset();
            if ($urandom_range(0, 2) == 0) send_byte(8'($urandom));
            else send_byte(pick[$urandom_range(0, pick.size() - 1)]);
        end

        check("pulse_total", dut_pulses, m_pulses);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
